// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Format codes, opcodes, stage bundle and immediate range check.
package rv_enc_pkg;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        err;
    } s1_t;

    function automatic logic imm_bad(
        input logic [2:0]  f,
        input logic [31:0] imm
    );
        logic bad;
        bad = 1'b1;
        case (f)
            FMT_I, FMT_S: bad = !(&imm[31:11] || ~|imm[31:11]);
            FMT_B: bad = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
            FMT_J: bad = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
            FMT_U: bad = |imm[11:0];
            FMT_R: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: S1 bundle to RV32I word.
// Erroneous bundles are replaced by the error word.
module instr_pack
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] ERR_WORD = NOP_WORD
) (
    input  s1_t         f,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] raw;

    // Bit concatenation per format, error word substituted last
    always_comb begin
        raw = '0;
        err = f.err;
        unique case (f.fmt)
            FMT_I: raw = {f.imm[11:0], f.rs1, f.funct3,
                          f.rd, f.opcode};
            FMT_S: raw = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:0], f.opcode};
            FMT_B: raw = {f.imm[12], f.imm[10:5], f.rs2, f.rs1,
                          f.funct3, f.imm[4:1], f.imm[11],
                          f.opcode};
            FMT_J: raw = {f.imm[20], f.imm[10:1], f.imm[11],
                          f.imm[19:12], f.rd, f.opcode};
            FMT_U: raw = {f.imm[31:12], f.rd, f.opcode};
            FMT_R: raw = {f.funct7, f.rs2, f.rs1, f.funct3,
                          f.rd, f.opcode};
            default: err = 1'b1;
        endcase
        word = err ? ERR_WORD : raw;
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides.
// S1 holds fields and range result, S2 holds the packed word.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] ERR_WORD = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        range_err,
    output logic [15:0] err_count
);

    logic        s1_valid;
    s1_t         s1_q;
    s1_t         s1_d;
    logic        s1_load;
    logic        s2_load;
    logic [31:0] pack_word;
    logic        pack_err;

    // Stage advance: each stage loads when empty or draining
    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // Input bundle with range check folded in
    always_comb begin
        s1_d.fmt    = fmt;
        s1_d.opcode = opcode;
        s1_d.rd     = rd;
        s1_d.rs1    = rs1;
        s1_d.rs2    = rs2;
        s1_d.funct3 = funct3;
        s1_d.funct7 = funct7;
        s1_d.imm    = imm;
        s1_d.err    = imm_bad(fmt, imm);
    end

    // S1 register: fields captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    instr_pack #(
        .ERR_WORD (ERR_WORD)
    ) u_pack (
        .f    (s1_q),
        .word (pack_word),
        .err  (pack_err)
    );

    // S2 register: output word held while consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            range_err <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr     <= pack_word;
                range_err <= pack_err;
            end
        end
    end

    // Saturating count of delivered error words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && range_err
                     && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder.
// Expected words queued at accept, compared at delivery.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        range_err;
    logic [15:0] err_count;

    logic        rdy_force = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        rnd_bit = 1'b1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] sb[$];
    logic [15:0] exp_cnt = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    logic        prev_err = 1'b0;

    assign out_ready = rnd_mode ? rnd_bit : rdy_force;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .range_err (range_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        int          v;
        logic        bad;
        logic [31:0] w;
        v   = $signed(im);
        bad = 1'b0;
        w   = '0;
        case (f)
            3'd0: begin
                bad = v < -2048 || v > 2047;
                w = {im[11:0], s1, f3, d, op};
            end
            3'd1: begin
                bad = v < -2048 || v > 2047;
                w = {im[11:5], s2, s1, f3, im[4:0], op};
            end
            3'd2: begin
                bad = v < -4096 || v > 4094 || im[0];
                w = {im[12], im[10:5], s2, s1, f3,
                     im[4:1], im[11], op};
            end
            3'd3: begin
                bad = v < -1048576 || v > 1048574 || im[0];
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            3'd4: begin
                bad = im[11:0] != 12'd0;
                w = {im[31:12], d, op};
            end
            3'd5: w = {f7, s2, s1, f3, d, op};
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    // Delivery monitor: scoreboard pop, count and hold checks
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_v", 32'(out_valid), 32'd1);
                check("hold_i", instr, prev_instr);
                check("hold_e", 32'(range_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                check("sb_extra", 32'(sb.size() != 0), 32'd1);
                check("errcnt", 32'(err_count), 32'(exp_cnt));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("instr", instr, e[31:0]);
                    check("rerr", 32'(range_err), 32'(e[32]));
                    if (e[32] && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = instr;
            prev_err   = range_err;
        end
    end

    task automatic try_send(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im,
        input logic [32:0] exp,
        input int          maxc,
        output bit         ok
    );
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_exp(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im,
        input logic [32:0] exp
    );
        bit ok;
        try_send(f, op, d, s1, s2, f3, f7, im, exp, 50, ok);
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic push_m(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        push_exp(f, op, d, s1, s2, f3, f7, im,
                 model(f, op, d, s1, s2, f3, f7, im));
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            @(negedge clk);
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_check();
        @(negedge clk);
        check("lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        logic [31:0] r;

        #2;
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_in", instr, 32'd0);
        check("rst_re", 32'(range_err), 32'd0);
        check("rst_ec", 32'(err_count), 32'd0);
        check("rst_ir", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_ir", 32'(in_ready), 32'd1);

        push_exp(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd5, {1'b0, 32'h0050_0093});
        lat_check();

        push_exp(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0,
                 32'd8, {1'b0, 32'h0020_A423});
        push_exp(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 -32'sd4, {1'b0, 32'hFE20_8EE3});
        push_exp(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd2048, {1'b1, 32'h0000_0013});
        push_exp(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 32'd3, {1'b1, 32'h0000_0013});
        drain();
        check("errcnt2", 32'(err_count), 32'd2);

        rdy_force = 1'b0;
        push_m(3'd5, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 0);
        push_m(3'd5, 7'b0110011, 5'd6, 5'd7, 5'd8, 3'd1, 7'h20, 0);
        r = 32'hABCD_E000;
        try_send(3'd4, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0,
                 r, model(3'd4, 7'b0110111, 5'd9, 5'd0, 5'd0,
                          3'd0, 7'd0, r), 3, ok);
        check("bp_block", 32'(ok), 32'd0);
        @(negedge clk);
        check("bp_inrdy", 32'(in_ready), 32'd0);
        check("bp_ov", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        push_m(3'd4, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, r);
        push_m(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
               32'h0000_0800);
        drain();

        rnd_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: r = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: r = $urandom();
                2: r = $urandom() & 32'hFFFF_F000;
                default: r = {{11{r[0]}},
                              21'($urandom()) & 21'h1F_FFFE};
            endcase
            push_m(f, 7'($urandom()), 5'($urandom()),
                   5'($urandom()), 5'($urandom()),
                   3'($urandom()), 7'($urandom()), r);
        end
        drain();
        rnd_mode = 1'b0;

        rdy_force = 1'b0;
        push_m(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        push_m(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        rst_n = 1'b0;
        #1;
        check("mr_ov", 32'(out_valid), 32'd0);
        check("mr_ec", 32'(err_count), 32'd0);
        check("mr_ir", 32'(in_ready), 32'd1);
        sb.delete();
        exp_cnt = '0;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd7, {1'b0, 32'h0070_0113});
        lat_check();
        drain();
        check("mr_ec2", 32'(err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
